// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state type and transfer-decode helpers.
// Used by ahb_sram_slave; no ports.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  function automatic logic [3:0] lane_mask(
    input logic [2:0] size,
    input logic [1:0] lo
  );
    logic [3:0] m;
    m = 4'b1111;
    unique case (1'b1)
      size == HSIZE_BYTE: m = 4'b0001 << lo;
      size == HSIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default:            m = 4'b1111;
    endcase
    return m;
  endfunction

  // Misaligned, oversized, or beyond the array (aw = word-address bits).
  function automatic logic bad_xfer(
    input logic [31:0] addr,
    input logic [2:0]  size,
    input int unsigned aw
  );
    logic b;
    b = (size > HSIZE_WORD)
      | ((size == HSIZE_HALF) & addr[0])
      | ((size == HSIZE_WORD) & (addr[1:0] != 2'b00))
      | ((addr >> (aw + 2)) != 32'd0);
    return b;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-lane-write, synchronous-read 32-bit SRAM array, 2**ADDR_W words.
// Ports: clk, we/be/waddr/wdata write port, raddr -> rdata (1-cycle).
module ahb_sram_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with WAIT_STATES wait cycles; ERROR responses when
// AHB_SRAM_ERR_RESP_EN is defined. Ports: AHB slave (HCLK..HRDATA).
module ahb_sram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);
  import ahb_pkg::*;

  localparam logic [2:0] WLOAD =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_t state, state_n;
  logic [2:0] cnt, cnt_n;

  logic              pend;
  logic              pend_wr;
  logic              pend_err;
  logic [ADDR_W-1:0] pend_word;
  logic [3:0]        pend_be;

  logic              accept;
  logic              done;
  logic              we;
  logic              bad;
  logic [ADDR_W-1:0] raddr;
  logic [31:0]       mem_rdata;
  logic [31:0]       rd_word;
  logic [31:0]       hold_q;

  logic              fwd;
  logic [3:0]        fwd_be;
  logic [31:0]       fwd_data;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign HREADYOUT = (state == ST_IDLE) | (state == ST_ERR2);

`ifdef AHB_SRAM_ERR_RESP_EN
  assign HRESP = ((state == ST_ERR1) | (state == ST_ERR2))
               ? HRESP_ERROR : HRESP_OKAY;
`else
  assign HRESP = HRESP_OKAY;
`endif

  assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign bad    = bad_xfer(HADDR, HSIZE, ADDR_W);
  assign done   = pend & HREADYOUT;
  assign we     = done & pend_wr & ~pend_err;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE, ST_ERR2: begin
        state_n = ST_IDLE;
        if (accept) begin
          if (ERR_EN && bad) begin
            state_n = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_n = ST_WAIT;
            cnt_n   = WLOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 3'd0) state_n = ST_IDLE;
        else             cnt_n   = cnt - 3'd1;
      end
`ifdef AHB_SRAM_ERR_RESP_EN
      ST_ERR1: state_n = ST_ERR2;
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Data-phase context; clearing pend on reset drops any pending write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend      <= 1'b0;
      pend_wr   <= 1'b0;
      pend_err  <= 1'b0;
      pend_word <= '0;
      pend_be   <= 4'd0;
    end else if (accept) begin
      pend      <= 1'b1;
      pend_wr   <= HWRITE;
      pend_err  <= bad;
      pend_word <= HADDR[ADDR_W+1:2];
      pend_be   <= lane_mask(HSIZE, HADDR[1:0]);
    end else if (done) begin
      pend      <= 1'b0;
    end
  end

  // Read the new address on accept so a zero-wait read is ready in time.
  assign raddr = accept ? HADDR[ADDR_W+1:2] : pend_word;

  ahb_sram_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (HCLK),
    .we    (we),
    .be    (pend_be),
    .waddr (pend_word),
    .wdata (HWDATA),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  // The array returns pre-write data when read and write share an edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd      <= 1'b0;
      fwd_be   <= 4'd0;
      fwd_data <= 32'd0;
    end else begin
      fwd      <= we & (pend_word == raddr);
      fwd_be   <= pend_be;
      fwd_data <= HWDATA;
    end
  end

  always_comb begin
    rd_word = mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd && fwd_be[b]) rd_word[8*b +: 8] = fwd_data[8*b +: 8];
    end
  end

  always_comb begin
    HRDATA = hold_q;
    if (done && !pend_wr) HRDATA = pend_err ? 32'd0 : rd_word;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hold_q <= 32'd0;
    else          hold_q <= HRDATA;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave (WAIT_STATES=1, ADDR_W=10).
// Honours AHB_SRAM_ERR_RESP_EN for the expected error responses.
module tb_ahb_sram_slave;

  localparam int W  = 1;
  localparam int AW = 10;

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(
    .ADDR_W      (AW),
    .WAIT_STATES (W)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          seq;
    logic [2:0]  burst;
    int          gap;
  } xfer_t;

  xfer_t       txq[$];
  logic [31:0] mdl [1024];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  function automatic bit m_err(logic [31:0] a, logic [2:0] s);
    return (s > 2) || (s == 1 && a % 2 != 0) ||
           (s == 2 && a % 4 != 0) || (a >= 32'd4096);
  endfunction

  function automatic void m_write(logic [31:0] a, logic [2:0] s,
                                  logic [31:0] d);
    int w;
    int k;
    w = int'(a / 4);
    if (s == 0) begin
      k = int'(a % 4);
      mdl[w][8*k +: 8] = d[8*k +: 8];
    end else if (s == 1) begin
      k = int'((a / 2) % 2);
      mdl[w][16*k +: 16] = d[16*k +: 16];
    end else begin
      mdl[w] = d;
    end
  endfunction

  task automatic push(logic [31:0] a, bit wr, logic [2:0] s,
                      logic [31:0] d, bit sq, logic [2:0] bu, int gap);
    xfer_t x;
    x.addr = a; x.wr = wr; x.size = s; x.wdata = d;
    x.seq = sq; x.burst = bu; x.gap = gap;
    txq.push_back(x);
  endtask

  task automatic idle_bus;
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HADDR = 32'd0;
  endtask

  // Pipelined master over txq; checks each completion against the model.
  task automatic run_q(output int cycles);
    int    i;
    int    gap;
    int    waits;
    bit    dpv;
    bit    rdy;
    bit    e;
    xfer_t d;
    i = 0; dpv = 0; waits = 0; cycles = 0;
    gap = (txq.size() > 0) ? txq[0].gap : 0;
    while ((i < txq.size() || dpv) && cycles < 2000) begin
      if (i < txq.size() && gap == 0) begin
        HSEL = 1'b1;
        HADDR = txq[i].addr;
        HTRANS = txq[i].seq ? 2'b11 : 2'b10;
        HWRITE = txq[i].wr;
        HSIZE = txq[i].size;
        HBURST = txq[i].burst;
      end else begin
        idle_bus();
      end
      HWDATA = dpv ? d.wdata : 32'd0;
      @(negedge HCLK);
      rdy = HREADYOUT;
      if (dpv) begin
        e = m_err(d.addr, d.size);
        if (!rdy) begin
          waits++;
          if (e && EN) begin
            checks++;
            if (HRESP !== 2'b01) begin
              errors++;
              $display("FAIL err1_resp addr=%h got %b want 01",
                       d.addr, HRESP);
            end
          end
        end else begin
          checks++;
          if (HRESP !== ((e && EN) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL resp addr=%h got %b want %b",
                     d.addr, HRESP, (e && EN) ? 2'b01 : 2'b00);
          end
          checks++;
          if (waits != ((e && EN) ? 1 : W)) begin
            errors++;
            $display("FAIL waits addr=%h got %0d want %0d",
                     d.addr, waits, (e && EN) ? 1 : W);
          end
          if (!d.wr && !(e && EN)) begin
            checks++;
            last_rd = HRDATA;
            if (HRDATA !== (e ? 32'd0 : mdl[d.addr / 4])) begin
              errors++;
              $display("FAIL rdata addr=%h got %h want %h", d.addr,
                       HRDATA, e ? 32'd0 : mdl[d.addr / 4]);
            end
          end
          if (d.wr && !e) m_write(d.addr, d.size, d.wdata);
          dpv = 0;
        end
      end
      @(posedge HCLK);
      #1;
      cycles++;
      if (gap > 0) begin
        gap--;
      end else if (rdy && i < txq.size()) begin
        d = txq[i];
        dpv = 1;
        waits = 0;
        i++;
        if (i < txq.size()) gap = txq[i].gap;
      end
    end
    if (cycles >= 2000) begin
      errors++;
      $display("FAIL timeout got %0d cycles want <2000", cycles);
    end
    idle_bus();
    HWDATA = 32'd0;
    txq.delete();
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", HREADYOUT);
    end
    checks++;
    if (HRESP !== 2'b00) begin
      errors++;
      $display("FAIL rst_resp got %b want 00", HRESP);
    end
    checks++;
    if (HRDATA !== 32'd0) begin
      errors++;
      $display("FAIL rst_rdata got %h want 0", HRDATA);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_init;
    int c;
    for (int k = 0; k < 32; k++) begin
      push(32'(4 * k), 1, 3'd2, $urandom, k != 0, 3'd1, 0);
    end
    run_q(c);
  endtask

  task automatic test_word_rw;
    int c;
    push(32'h10, 1, 3'd2, 32'hDEADBEEF, 0, 3'd0, 0);
    run_q(c);
    push(32'h10, 0, 3'd2, 32'h0, 0, 3'd0, 0);
    run_q(c);
    checks++;
    if (last_rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_rw got %h want deadbeef", last_rd);
    end
  endtask

  task automatic test_byte_lane;
    int c;
    push(32'h10, 1, 3'd2, 32'h11223344, 0, 3'd0, 0);
    push(32'h13, 1, 3'd0, 32'hAA000000, 0, 3'd0, 1);
    push(32'h10, 0, 3'd2, 32'h0, 0, 3'd0, 1);
    run_q(c);
    checks++;
    if (last_rd !== 32'hAA223344) begin
      errors++;
      $display("FAIL byte_lane got %h want aa223344", last_rd);
    end
  endtask

  task automatic test_burst;
    int c;
    for (int k = 0; k < 4; k++) begin
      push(32'(32'h20 + 4 * k), 1, 3'd2, 32'(k + 1), k != 0, 3'd3, 0);
    end
    run_q(c);
    checks++;
    if (c != 1 + 4 * (W + 1)) begin
      errors++;
      $display("FAIL burst_wr_cycles got %0d want %0d", c, 1 + 4 * (W + 1));
    end
    for (int k = 0; k < 4; k++) begin
      push(32'(32'h20 + 4 * k), 0, 3'd2, 32'h0, k != 0, 3'd3, 0);
    end
    run_q(c);
    checks++;
    if (c != 1 + 4 * (W + 1)) begin
      errors++;
      $display("FAIL burst_rd_cycles got %0d want %0d", c, 1 + 4 * (W + 1));
    end
    checks++;
    if (last_rd !== 32'd4) begin
      errors++;
      $display("FAIL burst_last got %h want 4", last_rd);
    end
  endtask

  task automatic test_idle_sel;
    int c;
    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = 32'h0; HSIZE = 3'd2;
    @(posedge HCLK);
    #1;
    HWDATA = 32'hFFFFFFFF;
    HSEL = 1'b1; HTRANS = 2'b01;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 2'b00) begin
      errors++;
      $display("FAIL unsel got %b/%b want 1/00", HREADYOUT, HRESP);
    end
    @(posedge HCLK);
    #1;
    idle_bus();
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 2'b00) begin
      errors++;
      $display("FAIL busy got %b/%b want 1/00", HREADYOUT, HRESP);
    end
    @(posedge HCLK);
    #1;
    HWDATA = 32'd0;
    push(32'h0, 0, 3'd2, 32'h0, 0, 3'd0, 0);
    run_q(c);
  endtask

  task automatic test_error;
    int c;
    push(32'h01, 1, 3'd1, 32'h5A5A5A5A, 0, 3'd0, 0);
    push(32'h00, 0, 3'd2, 32'h0, 0, 3'd0, 1);
    push(32'h2000, 1, 3'd2, 32'h12345678, 0, 3'd0, 1);
    push(32'h08, 1, 3'd3, 32'h87654321, 0, 3'd0, 1);
    push(32'h08, 0, 3'd2, 32'h0, 0, 3'd0, 0);
    run_q(c);
  endtask

  task automatic test_reset_mid;
    int c;
    HSEL = 1'b1; HADDR = 32'h40; HTRANS = 2'b10;
    HWRITE = 1'b1; HSIZE = 3'd2; HBURST = 3'd0;
    @(posedge HCLK);
    #1;
    idle_bus();
    HWDATA = ~mdl[16];
    checks++;
    if (HREADYOUT !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait got %b want 0", HREADYOUT);
    end
    #1;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 2'b00 || HRDATA !== 32'd0) begin
      errors++;
      $display("FAIL mid_rst got %b/%b/%h want 1/00/0",
               HREADYOUT, HRESP, HRDATA);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    HWDATA = 32'd0;
    @(posedge HCLK);
    #1;
    push(32'h40, 0, 3'd2, 32'h0, 0, 3'd0, 0);
    run_q(c);
  endtask

  task automatic test_random;
    int          c;
    logic [31:0] a;
    logic [2:0]  s;
    int          r;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 4095);
      else a = $urandom_range(0, 127);
      r = $urandom_range(0, 9);
      s = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
      if (s == 1 && $urandom_range(0, 3) != 0) a = a & ~32'd1;
      if (s == 2 && $urandom_range(0, 3) != 0) a = a & ~32'd3;
      push(a, $urandom_range(0, 1) == 1, s, $urandom, 0, 3'd0,
           ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    run_q(c);
  endtask

  initial begin
    HRESETn = 1'b0;
    idle_bus();
    HWDATA = 32'd0;
    last_rd = 32'd0;
    test_reset();
    test_init();
    test_word_rw();
    test_byte_lane();
    test_burst();
    test_idle_sel();
    test_error();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits (memory holds 2**ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..7, meaning HREADYOUT-low cycles per valid transfer.
REQ-003 SHALL have port HCLK  input  1  bus clock; all state changes on the rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port HSEL  input  1  slave select from the decoder.
REQ-006 SHALL have port HADDR  input  32  byte address.
REQ-007 SHALL have port HTRANS  input  2  transfer type: IDLE, BUSY, NONSEQ or SEQ.
REQ-008 SHALL have port HWRITE  input  1  1 = write.
REQ-009 SHALL have port HSIZE  input  3  transfer size.
REQ-010 SHALL have port HBURST  input  3  burst type; accepted, not used for addressing.
REQ-011 SHALL have port HWDATA  input  32  write data, valid in the data phase.
REQ-012 SHALL have port HREADY  input  1  bus-level ready that ends the current data phase.
REQ-013 SHALL have port HREADYOUT  output  1  this slave's ready.
REQ-014 SHALL have port HRESP  output  2  response: OKAY=00 or ERROR=01; RETRY and SPLIT are never driven.
REQ-015 SHALL have port HRDATA  output  32  read data.

Function
REQ-016 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; it SHALL register HADDR, HWRITE and HSIZE at that edge.
REQ-017 SHALL give IDLE or BUSY transfers, and unselected transfers, a zero-wait OKAY response (HREADYOUT=1, HRESP=00).
REQ-018 SHALL use an FSM with states IDLE, WAIT, ERR1 and ERR2:
- IDLE to WAIT on a valid accept when WAIT_STATES>0.
- WAIT holds HREADYOUT=0 for exactly WAIT_STATES cycles, counted by a 3-bit down-counter, then completes with HREADYOUT=1.
REQ-019 SHALL complete a valid transfer WAIT_STATES+1 cycles after its address-phase edge; with WAIT_STATES=0 it SHALL complete in the next cycle.
REQ-020 SHALL perform a write on the completing data-phase edge using HWDATA and these little-endian byte lanes:
- byte: lane HADDR[1:0]
- halfword: lanes {HADDR[1],0} and {HADDR[1],1}
- word: all 4 lanes
REQ-021 SHALL drive HRDATA with the full addressed word while HREADYOUT=1 in a read data phase, and SHALL hold it otherwise.
REQ-022 SHALL treat these cases as errors: halfword with HADDR[0]=1; word with HADDR[1:0]!=0; HSIZE>2; HADDR[31:ADDR_W+2] nonzero.
REQ-023 SHALL answer an error with a two-cycle ERROR response and SHALL suppress the write:
- ERR1: HREADYOUT=0, HRESP=01
- ERR2: HREADYOUT=1, HRESP=01
REQ-024 SHALL treat a new valid accept on the completing edge of a transfer as back-to-back pipelining, with no IDLE cycle inserted.
REQ-025 SHALL let a read that immediately follows a write to the same word return the newly written data.
REQ-026 SHALL end a non-BUSY burst after ERR2 when the master issues IDLE; a transfer accepted after ERR2 SHALL be handled normally.

Reset
REQ-027 SHALL, while HRESETn=0, force HREADYOUT=1, HRESP=00, HRDATA=0, state=IDLE and wait counter=0.
REQ-028 SHALL discard a write pending at the moment of reset; memory contents SHALL NOT be reset.

Configuration
REQ-029 SHALL support macro AHB_SRAM_ERR_RESP_EN:
- Defined: REQ-022 and REQ-023 apply.
- Undefined: error cases complete as normal OKAY transfers with the write dropped and HRDATA=0, and states ERR1/ERR2 are not built.

Structure
REQ-030 SHALL take the HTRANS, HRESP, HSIZE and HBURST encodings and the FSM state typedef from shared package ahb_pkg.
REQ-031 SHALL put storage in sub-module ahb_sram_mem, a 32-bit byte-lane-write, synchronous-read array of depth 2**ADDR_W.

Verification
REQ-032 (WAIT_STATES=1) SHALL cover: NONSEQ word write 0xDEADBEEF to 0x10, then read 0x10 -> HREADYOUT low 1 cycle per transfer, HRDATA=0xDEADBEEF, HRESP=00.
REQ-033 SHALL cover: byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 gives 0xAA223344.
REQ-034 SHALL cover: INCR4 word burst writing 1,2,3,4 to 0x20, then back-to-back reads -> 1,2,3,4 returned with no extra idle cycles.
REQ-035 (macro defined) SHALL cover: halfword write to 0x01 -> ERR1 then ERR2 with HRESP=01, memory unchanged; with the macro undefined -> OKAY and memory unchanged.
REQ-036 SHALL cover: HRESETn asserted during WAIT of a write to 0x40 -> outputs return to reset values asynchronously, and a later read of 0x40 returns the old contents.
